// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths and named colours for the sprite renderer.
// Used by sprite_hit_unit and sprite_engine_multi.
package sprite_pkg;

    localparam int RGB_W  = 24;
    localparam int HPOS_W = 12;
    localparam int VPOS_W = 11;

    localparam logic [RGB_W-1:0] WHITE  = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] INDIGO = 24'h4B0082;
    localparam logic [RGB_W-1:0] RED    = 24'hFF0000;

endpackage

// File: rtl/sprite_hit_unit.sv
// sprite_hit_unit: per-sprite double-buffered position/visibility and the
// first pipeline stage (window compare plus bitmap row/bit address).
// Ports: clk, reset (sync, high), commit (copy pending -> active),
//   wr/wr_x/wr_y/wr_show (pending write), tx/vpos (target pixel),
//   hit/row/col (registered S1 results).
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8,
    localparam int BW = $clog2(SPR_W),
    localparam int RW = $clog2(SPR_H)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     commit,
    input  logic                     wr,
    input  logic signed [HPOS_W-1:0] wr_x,
    input  logic signed [VPOS_W-1:0] wr_y,
    input  logic                     wr_show,
    input  logic signed [HPOS_W-1:0] tx,
    input  logic signed [VPOS_W-1:0] vpos,
    output logic                     hit,
    output logic [RW-1:0]            row,
    output logic [BW-1:0]            col
);

    logic signed [HPOS_W-1:0] act_x, pnd_x;
    logic signed [VPOS_W-1:0] act_y, pnd_y;
    logic                     act_show, pnd_show;

    // One extra bit so the difference of two signed values cannot wrap.
    logic [HPOS_W:0] dx;
    logic [VPOS_W:0] dy;
    logic            in_x, in_y;

    assign dx = {tx[HPOS_W-1], tx} - {act_x[HPOS_W-1], act_x};
    assign dy = {vpos[VPOS_W-1], vpos} - {act_y[VPOS_W-1], act_y};

    // 0 <= d < size (size a power of two): all bits above the index are zero.
    assign in_x = (dx[HPOS_W:BW] == '0);
    assign in_y = (dy[VPOS_W:RW] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            act_x    <= '0;
            act_y    <= '0;
            act_show <= 1'b0;
            pnd_x    <= '0;
            pnd_y    <= '0;
            pnd_show <= 1'b0;
            hit      <= 1'b0;
            row      <= '0;
            col      <= '0;
        end else begin
            if (wr) begin
                pnd_x    <= wr_x;
                pnd_y    <= wr_y;
                pnd_show <= wr_show;
            end
            if (commit) begin
                act_x    <= pnd_x;
                act_y    <= pnd_y;
                act_show <= pnd_show;
            end
            hit <= act_show && in_x && in_y;
            row <= dy[RW-1:0];
            // MSB is the leftmost pixel: bit = SPR_W-1-dx.
            col <= ~dx[BW-1:0];
        end
    end

endmodule

// File: rtl/sprite_engine_multi.sv
// sprite_engine_multi: NUM_SPR monochrome sprites composited over BG_COLOR,
// two-stage pipeline prefetching LOOKAHEAD pixels ahead of hPos.
// Ports: crystalCLK, reset, hPos/vPos/vSync (timing), cfg_* (buffered
//   position/visibility), col_* (colour), bm_* (bitmap rows), pixelOut,
//   collision. Optional: define SPRITE_COLLISION_EN for overlap detection.
module sprite_engine_multi
    import sprite_pkg::*;
#(
    parameter int                NUM_SPR   = 4,
    parameter int                SPR_W     = 8,
    parameter int                SPR_H     = 8,
    parameter logic [RGB_W-1:0]  BG_COLOR  = 24'hFFFFFF,
    parameter int                LOOKAHEAD = 2,
    localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int BW = $clog2(SPR_W),
    localparam int RW = $clog2(SPR_H)
) (
    input  logic                     crystalCLK,
    input  logic                     reset,
    input  logic signed [HPOS_W-1:0] hPos,
    input  logic signed [VPOS_W-1:0] vPos,
    input  logic                     vSync,
    input  logic                     cfg_we,
    input  logic [SW-1:0]            cfg_sel,
    input  logic signed [HPOS_W-1:0] cfg_x,
    input  logic signed [VPOS_W-1:0] cfg_y,
    input  logic                     cfg_show,
    input  logic                     col_we,
    input  logic [RGB_W-1:0]         col_data,
    input  logic                     bm_we,
    input  logic [SW-1:0]            bm_spr,
    input  logic [RW-1:0]            bm_row,
    input  logic [SPR_W-1:0]         bm_data,
    output logic [RGB_W-1:0]         pixelOut,
    output logic                     collision
);

    localparam logic [SW:0] NSPR = (SW+1)'(NUM_SPR);

    logic                     vs_d;
    logic                     commit;
    logic                     sel_ok, spr_ok;
    logic signed [HPOS_W-1:0] tx;

    logic [RGB_W-1:0] colr [NUM_SPR];
    logic [SPR_W-1:0] bmap [NUM_SPR][SPR_H];

    logic [NUM_SPR-1:0] hit;
    logic [RW-1:0]      row_s [NUM_SPR];
    logic [BW-1:0]      col_s [NUM_SPR];
    logic [NUM_SPR-1:0] opaque;
    logic [RGB_W-1:0]   pix;

    assign commit = vSync && !vs_d;
    assign sel_ok = ({1'b0, cfg_sel} < NSPR);
    assign spr_ok = ({1'b0, bm_spr} < NSPR);
    assign tx     = hPos + HPOS_W'(LOOKAHEAD);

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        sprite_hit_unit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H)
        ) u_hit (
            .clk     (crystalCLK),
            .reset   (reset),
            .commit  (commit),
            .wr      (cfg_we && sel_ok && (cfg_sel == SW'(i))),
            .wr_x    (cfg_x),
            .wr_y    (cfg_y),
            .wr_show (cfg_show),
            .tx      (tx),
            .vpos    (vPos),
            .hit     (hit[i]),
            .row     (row_s[i]),
            .col     (col_s[i])
        );
    end

    // Bitmap storage deliberately has no reset so patterns survive it.
    always_ff @(posedge crystalCLK) begin
        if (bm_we && spr_ok)
            bmap[bm_spr][bm_row] <= bm_data;
    end

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPR; i++)
            opaque[i] = hit[i] && bmap[i][row_s[i]][col_s[i]];
    end

    // Walk from lowest priority up so index 0 wins.
    always_comb begin
        pix = BG_COLOR;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (opaque[i])
                pix = colr[i];
    end

    always_ff @(posedge crystalCLK) begin
        if (reset) begin
            vs_d     <= 1'b0;
            pixelOut <= BG_COLOR;
            for (int i = 0; i < NUM_SPR; i++)
                colr[i] <= '0;
        end else begin
            vs_d     <= vSync;
            pixelOut <= pix;
            if (col_we && sel_ok)
                colr[cfg_sel] <= col_data;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic sticky;
    logic multi;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi = |(opaque & (opaque - NUM_SPR'(1)));

    always_ff @(posedge crystalCLK) begin
        if (reset) begin
            sticky    <= 1'b0;
            collision <= 1'b0;
        end else if (commit) begin
            collision <= sticky;
            sticky    <= 1'b0;
        end else if (multi) begin
            sticky <= 1'b1;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_engine_multi.sv
// tb_sprite_engine_multi: directed and randomized checks of the sprite
// renderer against a per-pixel reference model of the sprite rules.
module tb_sprite_engine_multi;
    import sprite_pkg::*;

    localparam int NS = 3;

    logic               crystalCLK = 1'b0;
    logic               reset;
    logic signed [11:0] hPos;
    logic signed [10:0] vPos;
    logic               vSync;
    logic               cfg_we;
    logic [1:0]         cfg_sel;
    logic signed [11:0] cfg_x;
    logic signed [10:0] cfg_y;
    logic               cfg_show;
    logic               col_we;
    logic [23:0]        col_data;
    logic               bm_we;
    logic [1:0]         bm_spr;
    logic [2:0]         bm_row;
    logic [7:0]         bm_data;
    logic [23:0]        pixelOut;
    logic               collision;

    sprite_engine_multi #(
        .NUM_SPR   (NS),
        .SPR_W     (8),
        .SPR_H     (8),
        .BG_COLOR  (24'hFFFFFF),
        .LOOKAHEAD (2)
    ) dut (
        .crystalCLK (crystalCLK),
        .reset      (reset),
        .hPos       (hPos),
        .vPos       (vPos),
        .vSync      (vSync),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_show   (cfg_show),
        .col_we     (col_we),
        .col_data   (col_data),
        .bm_we      (bm_we),
        .bm_spr     (bm_spr),
        .bm_row     (bm_row),
        .bm_data    (bm_data),
        .pixelOut   (pixelOut),
        .collision  (collision)
    );

    always #5 crystalCLK = ~crystalCLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          ax [NS], ay [NS], px [NS], py [NS];
    bit          ash [NS], psh [NS];
    logic [23:0] mcol [NS];
    logic [7:0]  mbm [NS][8];
    int          hist_tx [2], hist_v [2];
    int          nvalid;

    bit coll_on;

    function automatic logic [23:0] expect_pix(int tx, int v);
        for (int i = 0; i < NS; i++) begin
            int dx;
            int dy;
            dx = tx - ax[i];
            dy = v - ay[i];
            if (ash[i] && dx >= 0 && dx < 8 && dy >= 0 && dy < 8)
                if (mbm[i][dy][7-dx])
                    return mcol[i];
        end
        return WHITE;
    endfunction

    task automatic check_pix(input string tag, input logic [23:0] exp);
        vectors++;
        assert (pixelOut === exp) else begin
            miscompares++;
            $error("FAIL %s pixelOut=%h expected=%h", tag, pixelOut, exp);
        end
    endtask

    task automatic check_coll(input string tag, input logic exp);
        vectors++;
        assert (collision === exp) else begin
            miscompares++;
            $error("FAIL %s collision=%b expected=%b", tag, collision, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            ax[i] = 0; ay[i] = 0; ash[i] = 0;
            px[i] = 0; py[i] = 0; psh[i] = 0;
            mcol[i] = '0;
        end
    endtask

    // One pixel clock: check the pixel for the target two steps back,
    // then present the next timing position.
    task automatic step(input int h, input int v);
        @(posedge crystalCLK); #1;
        if (nvalid >= 2)
            check_pix($sformatf("pix x=%0d y=%0d", hist_tx[1], hist_v[1]),
                      expect_pix(hist_tx[1], hist_v[1]));
        hPos = 12'(h);
        vPos = 11'(v);
        hist_tx[1] = hist_tx[0];
        hist_v[1]  = hist_v[0];
        hist_tx[0] = h + 2;
        hist_v[0]  = v;
        nvalid++;
    endtask

    task automatic scan_row(input int v, input int h0, input int h1);
        nvalid = 0;
        for (int h = h0 - 2; h <= h1; h++)
            step(h, v);
    endtask

    task automatic cfg(input int sel, input int x, input int y, input bit sh);
        @(posedge crystalCLK); #1;
        cfg_we = 1; cfg_sel = 2'(sel);
        cfg_x = 12'(x); cfg_y = 11'(y); cfg_show = sh;
        @(posedge crystalCLK); #1;
        cfg_we = 0;
        if (sel < NS) begin
            px[sel] = x; py[sel] = y; psh[sel] = sh;
        end
    endtask

    task automatic col(input int sel, input logic [23:0] c);
        @(posedge crystalCLK); #1;
        col_we = 1; cfg_sel = 2'(sel); col_data = c;
        @(posedge crystalCLK); #1;
        col_we = 0;
        if (sel < NS) mcol[sel] = c;
    endtask

    task automatic bm(input int spr, input int r, input logic [7:0] d);
        @(posedge crystalCLK); #1;
        bm_we = 1; bm_spr = 2'(spr); bm_row = 3'(r); bm_data = d;
        @(posedge crystalCLK); #1;
        bm_we = 0;
        if (spr < NS) mbm[spr][r] = d;
    endtask

    task automatic solid(input int spr);
        for (int r = 0; r < 8; r++) bm(spr, r, 8'hFF);
    endtask

    task automatic vsync();
        @(posedge crystalCLK); #1;
        hPos = -12'sd500; vPos = -11'sd500;
        vSync = 1;
        repeat (3) @(posedge crystalCLK);
        #1 vSync = 0;
        repeat (2) @(posedge crystalCLK);
        #1;
        for (int i = 0; i < NS; i++) begin
            ax[i] = px[i]; ay[i] = py[i]; ash[i] = psh[i];
        end
    endtask

    logic [7:0] fpat [8];

    initial begin
`ifdef SPRITE_COLLISION_EN
        coll_on = 1;
`else
        coll_on = 0;
`endif
        fpat[0] = 8'b1111_1100; fpat[1] = 8'b1100_0000;
        fpat[2] = 8'b1100_0000; fpat[3] = 8'b1111_1000;
        fpat[4] = 8'b1100_0000; fpat[5] = 8'b1100_0000;
        fpat[6] = 8'b1100_0000; fpat[7] = 8'b0000_0000;
        for (int i = 0; i < NS; i++)
            for (int r = 0; r < 8; r++) mbm[i][r] = '0;
        model_reset();
        reset = 1; hPos = 0; vPos = 0; vSync = 0;
        cfg_we = 0; cfg_sel = 0; cfg_x = 0; cfg_y = 0; cfg_show = 0;
        col_we = 0; col_data = 0; bm_we = 0; bm_spr = 0; bm_row = 0;
        bm_data = 0; nvalid = 0;
        hist_tx[0] = 0; hist_tx[1] = 0; hist_v[0] = 0; hist_v[1] = 0;
        repeat (3) @(posedge crystalCLK);
        #1;
        check_pix("reset_pixel", WHITE);
        check_coll("reset_coll", 1'b0);
        reset = 0;

        // 1: idle frame is all background
        scan_row(0, 0, 320);
        scan_row(50, 0, 320);
        check_coll("idle_coll", 1'b0);

        // Out-of-range sprite index writes are ignored
        cfg(3, 0, 0, 1);
        col(3, RED);
        bm(3, 0, 8'hFF);
        vsync();
        scan_row(0, 0, 10);

        // 2: "F" pattern, sprite 0 at (100,50)
        for (int r = 0; r < 8; r++) bm(0, r, fpat[r]);
        col(0, INDIGO);
        cfg(0, 100, 50, 1);
        scan_row(50, 96, 110);
        vsync();
        scan_row(49, 96, 110);
        scan_row(50, 96, 110);
        scan_row(53, 96, 110);
        scan_row(57, 96, 110);
        scan_row(58, 96, 110);

        // 3: overlapping solid sprites, index 0 wins
        solid(0);
        solid(1);
        col(0, RED);
        col(1, INDIGO);
        cfg(0, 200, 10, 1);
        cfg(1, 203, 12, 1);
        vsync();
        for (int v = 9; v <= 20; v++) scan_row(v, 196, 214);
        cfg(1, 203, 12, 0);
        vsync();
        check_coll("overlap_frame", coll_on);
        scan_row(12, 196, 214);
        vsync();
        check_coll("clean_frame", 1'b0);

        // 4: mid-frame move stays pending until vSync
        cfg(0, 100, 50, 1);
        vsync();
        scan_row(52, 96, 110);
        cfg(0, 300, 50, 1);
        scan_row(52, 96, 110);
        scan_row(52, 296, 310);
        vsync();
        scan_row(52, 96, 110);
        scan_row(52, 296, 310);

        // 5: clipping at negative position
        solid(2);
        col(2, 24'h00FF00);
        cfg(0, 300, 50, 0);
        cfg(2, -3, -2, 1);
        vsync();
        for (int v = 0; v <= 7; v++) scan_row(v, 0, 8);

        // 6: reset during drawing
        cfg(2, -3, -2, 0);
        for (int r = 0; r < 8; r++) bm(0, r, fpat[r]);
        col(0, INDIGO);
        cfg(0, 100, 50, 1);
        vsync();
        scan_row(50, 96, 102);
        check_pix("pre_reset", INDIGO);
        reset = 1;
        @(posedge crystalCLK); #1;
        check_pix("reset_flush", WHITE);
        @(posedge crystalCLK); #1;
        check_pix("reset_hold", WHITE);
        check_coll("reset_coll2", 1'b0);
        reset = 0;
        model_reset();
        scan_row(50, 96, 110);
        col(0, INDIGO);
        cfg(0, 100, 50, 1);
        vsync();
        for (int v = 49; v <= 58; v++) scan_row(v, 96, 110);

        // Randomized scenes
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < NS; i++) begin
                for (int r = 0; r < 8; r++) bm(i, r, 8'($urandom));
                col(i, 24'($urandom));
                cfg(i, int'($urandom_range(0, 70)) - 10,
                    int'($urandom_range(0, 24)) - 4,
                    $urandom_range(0, 3) != 0);
            end
            vsync();
            repeat (8) scan_row(int'($urandom_range(0, 24)) - 4, 0, 75);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_engine_multi.md
Name: sprite_engine_multi

Overview:
Parametrised multi-sprite renderer sitting between the HDMI timing counters and hdmi_tx colour inputs. It holds NUM_SPR monochrome bitmaps of SPR_W x SPR_H pixels, each with its own position, colour and visibility. Position and visibility are double-buffered and committed at the start of vSync so moves are tear-free. It outputs a registered 24-bit {R8,G8,B8} pixel, pre-fetched so it lines up with the current hPos at the transmitter.

Parameters:
NUM_SPR, 4, number of sprites (1..8); index 0 has highest priority
SPR_W, 8, sprite width in pixels (power of 2, 4..32)
SPR_H, 8, sprite height in rows (power of 2, 4..32)
BG_COLOR, 24'hFFFFFF, colour output where no sprite pixel is opaque
LOOKAHEAD, 2, pixel prefetch distance; equals pipeline latency, fixed at 2

Ports:
crystalCLK  in  1  pixel clock
reset  in  1  synchronous active-high reset
hPos  in  12 signed  horizontal counter from hdmi_tx
vPos  in  11 signed  vertical counter from hdmi_tx
vSync  in  1  vertical sync from hdmi_tx
cfg_we  in  1  write the pending position/visibility for sprite cfg_sel
cfg_sel  in  $clog2(NUM_SPR)  sprite index for cfg_we / col_we
cfg_x  in  12 signed  pending top-left X
cfg_y  in  11 signed  pending top-left Y
cfg_show  in  1  pending visibility
col_we  in  1  write sprite colour immediately (not buffered)
col_data  in  24  sprite colour
bm_we  in  1  write one bitmap row
bm_spr  in  $clog2(NUM_SPR)  bitmap sprite index
bm_row  in  $clog2(SPR_H)  bitmap row
bm_data  in  SPR_W  row bits, MSB = leftmost pixel
pixelOut  out  24  registered pixel colour
collision  out  1  (SPRITE_COLLISION_EN only) sticky overlap flag for the previous frame

Behaviour:
- Single clock domain on crystalCLK. Reset is synchronous and active-high.
- Reset state: pixelOut=BG_COLOR; active and pending x=0, y=0, show=0 for all sprites; colours=24'h000000; collision=0. Bitmap storage is not reset: initial contents are zero, and written rows persist across reset.
- Config writes:
  - cfg_we updates only the pending set.
  - On the cycle after a vSync rising edge (registered edge detect), pending copies into active for all sprites at once.
  - A cfg_we in the same cycle as the commit lands in pending and takes effect at the next frame.
  - col_we and bm_we take effect next cycle, unbuffered; mid-frame tearing is accepted.
  - Out-of-range cfg_sel or bm_spr (index >= NUM_SPR) is ignored.
- Pipeline; target column tx = hPos + LOOKAHEAD, computed as 12-bit signed:
  - S1 (registered), per sprite: dx = tx - x and dy = vPos - y, full signed width.
  - S1 hit_i = show_i && 0<=dx<SPR_W && 0<=dy<SPR_H.
  - S1 also registers addresses row=dy[log2 SPR_H-1:0] and bit=SPR_W-1-dx.
  - S2 (registered): opaque_i = hit_i && bmap[i][row][bit].
  - S2 output: pixelOut = colour of the lowest-index opaque sprite, else BG_COLOR.
  - pixelOut therefore corresponds to the hPos value present at the output cycle.
- Boundaries:
  - Negative or off-screen positions clip naturally; no wrap-around of sprites across edges.
  - tx overflowing 12 bits is not a concern for the timing ranges in use.
  - Reset mid-frame: the pipeline flushes to BG_COLOR and holds there for 2 cycles.

Optional Feature:
SPRITE_COLLISION_EN:
- Defined:
  - An internal sticky bit sets when two or more opaque_i are asserted in the same S2 cycle.
  - On each vSync commit, collision takes the sticky value and the sticky bit clears.
  - collision thus reports the frame just completed, stable for a full frame.
- Undefined: port collision is tied to 0 and no detection logic is built.

Decomposition:
- Package sprite_pkg: RGB colour width (24), named colours (WHITE, INDIGO, RED), and the hPos/vPos widths (12/11).
- One natural sub-module, sprite_hit_unit, instantiated NUM_SPR times. Per sprite it holds the active/pending position and the S1 compare/address logic.
- The bitmap array, priority mux and collision logic stay in the top.

Test Plan:
1. Reset, then free-run one frame -> every pixelOut is 24'hFFFFFF and collision=0.
2. Sprite 0 loaded with the 8x8 "F" pattern (row0=8'b1111_1100), cfg x=100, y=50, show=1, colour INDIGO, then a vSync -> row 50, hPos 100..105 INDIGO, hPos 106..107 WHITE; no sprite pixels on rows 49 or 58.
3. Sprites 0 and 1 both solid, x=200, y=10; colour0=RED, colour1=INDIGO -> overlap pixels are RED; with SPRITE_COLLISION_EN, collision=1 after the next vSync.
4. cfg_we changes x from 100 to 300 mid-frame -> the current frame still draws at 100; the next frame after vSync draws at 300.
5. x=-3, y=-2, solid sprite -> pixels at hPos 0..4 on vPos 0..5 coloured, nothing else.
6. Assert reset while a sprite pixel is being drawn -> pixelOut=BG_COLOR within 1 cycle; sprite hidden afterwards; bitmap retained, so re-enabling via cfg_we plus vSync draws the same pattern.
